// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU codes, states and IR field positions for the CPU
package cpu_pkg;

  // Instruction opcodes, IR[4:0]
  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_OR   = 5'h02;
  localparam logic [4:0] OP_AND  = 5'h03;
  localparam logic [4:0] OP_XOR  = 5'h04;
  localparam logic [4:0] OP_SL   = 5'h05;
  localparam logic [4:0] OP_SR   = 5'h06;
  localparam logic [4:0] OP_ADDI = 5'h07;
  localparam logic [4:0] OP_SUBI = 5'h08;
  localparam logic [4:0] OP_ORI  = 5'h09;
  localparam logic [4:0] OP_ANDI = 5'h0A;
  localparam logic [4:0] OP_XORI = 5'h0B;
  localparam logic [4:0] OP_SLI  = 5'h0C;
  localparam logic [4:0] OP_SRI  = 5'h0D;
  localparam logic [4:0] OP_BR   = 5'h0E;
  localparam logic [4:0] OP_GT   = 5'h0F;
  localparam logic [4:0] OP_LT   = 5'h10;
  localparam logic [4:0] OP_EQ   = 5'h11;
  localparam logic [4:0] OP_STW  = 5'h12;
  localparam logic [4:0] OP_LDW  = 5'h13;

  // Codes understood by the external registered ALU
  localparam logic [3:0] ALU_IDLE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SL   = 4'd6;
  localparam logic [3:0] ALU_SR   = 4'd7;
  localparam logic [3:0] ALU_GT   = 4'd8;
  localparam logic [3:0] ALU_LT   = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;

  // IR field positions
  localparam int OP_LSB  = 0;
  localparam int RD_LSB  = 5;
  localparam int RA_LSB  = 8;
  localparam int RB_LSB  = 11;
  localparam int IMM_LSB = 11;

  // Bit of the flag register holding the last compare result
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_MEM,
    S_ILLEGAL
  } state_e;

endpackage

// File: rtl/cpu_decode.sv
// rtl/cpu_decode.sv - combinational instruction decoder: IR to ALU code, class flags and field selects
module cpu_decode
  import cpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] ir,
  output logic [3:0]    alu_op,
  output logic          is_imm,
  output logic          is_br,
  output logic          is_ld,
  output logic          is_st,
  output logic          is_cmp,
  output logic          is_illegal,
  output logic [2:0]    rd_sel,
  output logic [2:0]    ra_sel,
  output logic [2:0]    rb_sel,
  output logic [4:0]    imm5
);

  logic [4:0] op;

  assign op     = ir[OP_LSB +: 5];
  assign rd_sel = ir[RD_LSB +: 3];
  assign ra_sel = ir[RA_LSB +: 3];
  assign rb_sel = ir[RB_LSB +: 3];
  assign imm5   = ir[IMM_LSB +: 5];

  // Map each opcode onto its ALU code and instruction class
  always_comb begin
    alu_op     = ALU_IDLE;
    is_imm     = (op >= OP_ADDI) && (op <= OP_SRI);
    is_br      = 1'b0;
    is_ld      = 1'b0;
    is_st      = 1'b0;
    is_cmp     = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: alu_op = ALU_ADD;
      OP_SUB, OP_SUBI: alu_op = ALU_SUB;
      OP_OR,  OP_ORI:  alu_op = ALU_OR;
      OP_AND, OP_ANDI: alu_op = ALU_AND;
      OP_XOR, OP_XORI: alu_op = ALU_XOR;
      OP_SL,  OP_SLI:  alu_op = ALU_SL;
      OP_SR,  OP_SRI:  alu_op = ALU_SR;
      OP_GT: begin
        alu_op = ALU_GT;
        is_cmp = 1'b1;
      end
      OP_LT: begin
        alu_op = ALU_LT;
        is_cmp = 1'b1;
      end
      OP_EQ: begin
        alu_op = ALU_EQ;
        is_cmp = 1'b1;
      end
      OP_BR:  is_br = 1'b1;
      OP_STW: is_st = 1'b1;
      OP_LDW: is_ld = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute control unit owning PC, IR and flag
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [DW-1:0]   imem_rdata,
  output logic [2:0]      rf_ra_sel,
  output logic [2:0]      rf_rb_sel,
  input  logic [DW-1:0]   rf_ra_data,
  input  logic [DW-1:0]   rf_rb_data,
  output logic [3:0]      alu_op,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  input  logic [DW-1:0]   alu_out,
  output logic            rf_we,
  output logic [2:0]      rf_wsel,
  output logic [DW-1:0]   rf_wdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [DW-1:0]   dmem_addr,
  output logic [DW-1:0]   dmem_wdata,
  input  logic            dmem_ack,
  input  logic [DW-1:0]   dmem_rdata,
  output logic [PC_W-1:0] pc,
  output logic            flag,
  output logic            illegal
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [DW-1:0]   ir_q, ir_d;
  logic [DW-1:0]   opa_q, opa_d;
  logic [DW-1:0]   opb_q, opb_d;
  // Only FR[FLAG_Z] carries state, so the flag register is a single bit
  logic            fr_q, fr_d;
  logic            illegal_q, illegal_d;

  logic [3:0]      dec_alu_op;
  logic            is_imm, is_br, is_ld, is_st, is_cmp, is_illegal;
  logic [2:0]      rd_sel, ra_sel, rb_sel;
  logic [4:0]      imm5;
  logic [DW-1:0]   imm_zext;
  logic [PC_W-1:0] br_off;
  state_e          after_insn;

  cpu_decode #(.DW(DW)) u_decode (
    .ir         (ir_q),
    .alu_op     (dec_alu_op),
    .is_imm     (is_imm),
    .is_br      (is_br),
    .is_ld      (is_ld),
    .is_st      (is_st),
    .is_cmp     (is_cmp),
    .is_illegal (is_illegal),
    .rd_sel     (rd_sel),
    .ra_sel     (ra_sel),
    .rb_sel     (rb_sel),
    .imm5       (imm5)
  );

  assign imm_zext   = {{(DW-5){1'b0}}, imm5};
  assign br_off     = {{(PC_W-5){imm5[4]}}, imm5};
  // run is only looked at when the next instruction would be fetched
  assign after_insn = run ? S_FETCH : S_IDLE;

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign flag      = fr_q;
  assign illegal   = illegal_q;

  // State and architectural registers; reset drops every request at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      fr_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      fr_q      <= fr_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state plus PC/IR/operand/flag updates
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    fr_d      = fr_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        opa_d = rf_ra_data;
        opb_d = is_imm ? imm_zext : rf_rb_data;
        if (is_illegal) begin
          illegal_d = 1'b1;
          state_d   = S_ILLEGAL;
        end else if (is_br) begin
          // pc already points past the branch; offset wraps mod 2^PC_W
          if (fr_q) pc_d = pc_q + br_off;
          state_d = after_insn;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        if (is_cmp) fr_d = alu_out[0];
        state_d = after_insn;
      end
      S_MEM: begin
        if (dmem_ack) state_d = after_insn;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_IDLE;
    endcase
  end

  // Per-state drive of the memory, register-file and ALU interfaces
  always_comb begin
    imem_req   = 1'b0;
    rf_ra_sel  = 3'd0;
    rf_rb_sel  = 3'd0;
    alu_op     = ALU_IDLE;
    alu_a      = '0;
    alu_b      = '0;
    rf_we      = 1'b0;
    rf_wsel    = 3'd0;
    rf_wdata   = '0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    case (state_q)
      S_FETCH: imem_req = 1'b1;
      S_DECODE: begin
        rf_ra_sel = ra_sel;
        // stores read their data register through port B
        rf_rb_sel = is_st ? rd_sel : rb_sel;
      end
      S_EXEC: begin
        alu_op = dec_alu_op;
        alu_a  = opa_q;
        alu_b  = opb_q;
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_wsel  = rd_sel;
        rf_wdata = alu_out;
      end
      S_MEM: begin
        dmem_req   = 1'b1;
        dmem_we    = is_st;
        dmem_addr  = opa_q + imm_zext;
        dmem_wdata = opb_q;
        if (dmem_ack && is_ld) begin
          rf_we    = 1'b1;
          rf_wsel  = rd_sel;
          rf_wdata = dmem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule
